// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
//   Sits downstream of the multifunction ALU and captures each result (signed,
//   N+2 bits) with the 3-bit opcode that produced it into a DEPTH-entry FIFO.
//   Results leave over a valid/ready handshake in show-ahead form, with
//   zero/negative flags taken from the stored head entry. A 16-bit wrapping
//   counter tracks how many results have been accepted since reset.
//
// Ports
//   clk         in   1            rising-edge clock
//   reset       in   1            synchronous, active-high reset
//   in_valid    in   1            ALU result on in_result/in_op is valid
//   in_ready    out  1            buffer can accept this cycle
//   in_op       in   3            opcode that produced the result
//   in_result   in   N+2          signed ALU result
//   out_valid   out  1            head entry valid
//   out_ready   in   1            consumer takes the head this cycle
//   out_op      out  3            head opcode (0 when empty)
//   out_result  out  N+2          head result, signed (0 when empty)
//   out_zero    out  1            head result == 0 (0 when empty)
//   out_neg     out  1            head result is negative (0 when empty)
//   level       out  clog2(D)+1   entries currently held
//   total_cnt   out  16           results accepted since reset, wraps
// -----------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic signed [N+1:0]      in_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_op,
    output logic signed [N+1:0]      out_result,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              total_cnt
);

    localparam int RW = N + 2;              // result width
    localparam int EW = RW + 3;             // stored entry: {op, result}
    localparam int AW = $clog2(DEPTH);      // pointer width
    localparam int LW = AW + 1;             // level width
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Zero detect on a stored result.
    function automatic logic is_zero(input logic [RW-1:0] v);
        return (v == {RW{1'b0}});
    endfunction

    // Sign detect on a stored result (two's complement MSB).
    function automatic logic is_neg(input logic [RW-1:0] v);
        return v[RW-1];
    endfunction

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, wr_ptr_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_s;
    logic [LW-1:0] level_r, level_s;
    logic [15:0]   cnt_r, cnt_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;

    assign full_s    = (level_r == FULL_LVL);
    assign empty_s   = (level_r == {LW{1'b0}});
    // No full bypass: a pop in the same cycle does not open a slot for a push.
    assign in_ready  = !full_s && !reset;
    assign out_valid = !empty_s;
    // Empty-cycle out_ready is harmless because out_valid gates the pop.
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign head_s    = mem_r[rd_ptr_r];

    // Show-ahead head presentation, forced to zero while empty.
    always_comb begin
        out_op     = 3'b000;
        out_result = {RW{1'b0}};
        out_zero   = 1'b0;
        out_neg    = 1'b0;
        if (out_valid) begin
            out_op     = head_s[EW-1:RW];
            out_result = head_s[RW-1:0];
            out_zero   = is_zero(head_s[RW-1:0]);
            out_neg    = is_neg(head_s[RW-1:0]);
        end else begin
            out_op     = 3'b000;
            out_result = {RW{1'b0}};
            out_zero   = 1'b0;
            out_neg    = 1'b0;
        end
    end

    assign level     = level_r;
    assign total_cnt = cnt_r;

    // Next-state for pointers, occupancy and accepted-result counter.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        level_s  = level_r;
        cnt_s    = cnt_r;
        if (push_s) begin
            wr_ptr_s = wr_ptr_r + AW'(1);
            cnt_s    = cnt_r + 16'd1;
        end else begin
            wr_ptr_s = wr_ptr_r;
            cnt_s    = cnt_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LW'(1);
            2'b01:   level_s = level_r - LW'(1);
            default: level_s = level_r;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            cnt_r    <= 16'd0;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            level_r  <= level_s;
            cnt_r    <= cnt_s;
        end
    end

    // Entry storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_op, in_result};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
//   Directed bench for alu_result_buffer (N=4, DEPTH=4). A queue-based model
//   tracks the expected contents; a negedge process compares every output
//   against it, and directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        int op;
        int res;
    } entry_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic signed [5:0] in_result;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_op;
    logic signed [5:0] out_result;
    logic              out_zero;
    logic              out_neg;
    logic [2:0]        level;
    logic [15:0]       total_cnt;

    entry_t q[$];
    int     m_cnt    = 0;
    int     n_pass   = 0;
    int     n_total  = 0;
    bit     cmp_on   = 1'b0;

    alu_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .level      (level),
        .total_cnt  (total_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Apply inputs for one cycle, advance the model at the edge, return #1 later.
    task automatic drive(input int v, input int op, input int r, input int rdy,
                         input int rst);
        bit pu;
        bit po;
        entry_t e;
        in_valid  = (v != 0);
        in_op     = 3'(op);
        in_result = 6'(r);
        out_ready = (rdy != 0);
        reset     = (rst != 0);
        @(posedge clk);
        if (rst != 0) begin
            q.delete();
            m_cnt = 0;
        end else begin
            pu = (v != 0) && (q.size() < DEPTH);
            po = (rdy != 0) && (q.size() > 0);
            if (po) void'(q.pop_front());
            if (pu) begin
                e.op  = op & 7;
                e.res = r;
                q.push_back(e);
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
        cmp_on = 1'b1;
        #1;
    endtask

    // Every-cycle comparison of all outputs against the queue model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("m_in_ready", in_ready, (!reset && q.size() < DEPTH) ? 1 : 0);
                chk("m_out_valid", out_valid, (q.size() > 0) ? 1 : 0);
                chk("m_level", level, q.size());
                chk("m_total_cnt", total_cnt, m_cnt);
                if (q.size() > 0) begin
                    chk("m_out_op", out_op, q[0].op);
                    chk("m_out_result", out_result, q[0].res);
                    chk("m_out_zero", out_zero, (q[0].res == 0) ? 1 : 0);
                    chk("m_out_neg", out_neg, (q[0].res < 0) ? 1 : 0);
                end else begin
                    chk("m_empty_op", out_op, 0);
                    chk("m_empty_result", out_result, 0);
                    chk("m_empty_zero", out_zero, 0);
                    chk("m_empty_neg", out_neg, 0);
                end
            end
        end
    end

    int exp2 [4] = '{3, 0, -1, 31};

    initial begin
        in_valid = 1'b0; in_op = 3'd0; in_result = 6'sd0;
        out_ready = 1'b0; reset = 1'b1;

        // Reset state
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_total", total_cnt, 0);

        // 1: single push of -6, op 3
        drive(1, 3, -6, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_result", out_result, -6);
        chk("t1_op", out_op, 3);
        chk("t1_neg", out_neg, 1);
        chk("t1_zero", out_zero, 0);
        chk("t1_level", level, 1);
        chk("t1_total", total_cnt, 1);

        // 2: fill, ignored 5th push, drain in order
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, i + 1, exp2[i], 0, 0);
        chk("t2_level_full", level, 4);
        chk("t2_in_ready", in_ready, 0);
        drive(1, 7, 5, 0, 0);
        chk("t2_total", total_cnt, 4);
        chk("t2_level_hold", level, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_result", out_result, exp2[i]);
            chk("t2_drain_zero", out_zero, (i == 1) ? 1 : 0);
            drive(0, 0, 0, 1, 0);
        end
        chk("t2_empty", out_valid, 0);

        // 3: full with push+pop -> pop only, push lands next cycle
        for (int i = 0; i < 4; i++) drive(1, i, i + 1, 0, 0);
        drive(1, 5, 9, 1, 0);
        chk("t3_level_after_pop", level, 3);
        chk("t3_in_ready", in_ready, 1);
        chk("t3_head", out_result, 2);
        drive(1, 5, 9, 0, 0);
        chk("t3_level_refill", level, 4);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
        chk("t3_drained", level, 0);

        // 4: empty with push and out_ready -> no pop
        drive(1, 6, -32, 1, 0);
        chk("t4_level", level, 1);
        chk("t4_head", out_result, -32);
        chk("t4_neg", out_neg, 1);

        // 5: steady stream, level stays at 1 while pointers wrap
        for (int i = 0; i < 10; i++) begin
            drive(1, i, i * 3 - 7, 1, 0);
            chk("t5_level", level, 1);
            chk("t5_head", out_result, i * 3 - 7);
        end
        drive(0, 0, 0, 1, 0);

        // 6: reset mid-stream at level 3
        for (int i = 0; i < 3; i++) drive(1, 1, i + 10, 0, 0);
        chk("t6_level3", level, 3);
        drive(0, 0, 0, 0, 1);
        chk("t6_valid", out_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_total", total_cnt, 0);
        chk("t6_in_ready", in_ready, 0);
        drive(1, 7, 13, 0, 0);
        chk("t6_head", out_result, 13);
        chk("t6_op", out_op, 7);
        chk("t6_total_after", total_cnt, 1);
        drive(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
